// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Register map offsets, relative to the first address after the duty registers
  localparam int ADDR_PRESC_OFS = 0;
  localparam int ADDR_POL_OFS   = 1;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter and period boundary detection.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc_reg,
  input  logic               mode,
  output logic [WIDTH-1:0]   cnt,
  output logic               tick,
  output logic               last,
  output logic               period_start
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [PRESC_W-1:0] pcnt;
  logic [WIDTH-1:0]   cnt_next;
  logic               mode_act;
  logic               boundary;
  dir_t               dir;
  dir_t               dir_next;

  // last marks the final count of a period; the tick taken there returns cnt to 0
  always_comb begin
    tick     = (pcnt == presc_reg);
    last     = (mode_act == MODE_CENTER) ? ((dir == DOWN) && (cnt == ONE)) : (cnt == MAX);
    boundary = tick && last;
    cnt_next = cnt;
    dir_next = dir;
    if (boundary) begin
      cnt_next = '0;
      dir_next = UP;
    end else if (tick) begin
      if ((mode_act == MODE_CENTER) && (dir == DOWN)) begin
        cnt_next = cnt - ONE;
      end else if ((mode_act == MODE_CENTER) && (cnt == MAX)) begin
        cnt_next = MAX - ONE;
        dir_next = DOWN;
      end else begin
        cnt_next = cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt         <= '0;
      cnt          <= '0;
      dir          <= UP;
      mode_act     <= MODE_EDGE;
      period_start <= 1'b0;
    end else begin
      pcnt         <= tick ? '0 : pcnt + PRESC_W'(1);
      cnt          <= cnt_next;
      dir          <= dir_next;
      period_start <= boundary;
      if (boundary) begin
        mode_act <= mode;
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with double-buffered duty registers and a shared timebase.
// Define PWM_POLARITY_EN to add a double-buffered per-channel output polarity register.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 8,
  localparam int DATA_W  = max_int(WIDTH, PRESC_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                mode,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [3:0] PRESC_ADDR = 4'(CHANNELS + ADDR_PRESC_OFS);

  logic [WIDTH-1:0]    duty_shadow [CHANNELS];
  logic [WIDTH-1:0]    duty_act    [CHANNELS];
  logic [PRESC_W-1:0]  presc_reg;
  logic [WIDTH-1:0]    cnt;
  logic                tick;
  logic                last;
  logic                load;
  logic [CHANNELS-1:0] pol_act;
  logic [CHANNELS-1:0] cmp;

  pwm_timebase #(
    .WIDTH  (WIDTH),
    .PRESC_W(PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .presc_reg   (presc_reg),
    .mode        (mode),
    .cnt         (cnt),
    .tick        (tick),
    .last        (last),
    .period_start(period_start)
  );

  assign load = tick && last;

  // The prescaler is not buffered, so a new value applies from the next clock
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_shadow[i] <= '0;
      end
      presc_reg <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_addr == 4'(i)) begin
          duty_shadow[i] <= wr_data[WIDTH-1:0];
        end
      end
      if (wr_addr == PRESC_ADDR) begin
        presc_reg <= wr_data[PRESC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= duty_shadow[i];
      end
    end
  end

`ifdef PWM_POLARITY_EN
  localparam logic [3:0] POL_ADDR = 4'(CHANNELS + ADDR_POL_OFS);

  logic [CHANNELS-1:0] pol_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      pol_shadow <= '0;
      pol_act    <= '0;
    end else begin
      if (wr_en && (wr_addr == POL_ADDR)) begin
        pol_shadow <= wr_data[CHANNELS-1:0];
      end
      if (load) begin
        pol_act <= pol_shadow;
      end
    end
  end
`else
  assign pol_act = '0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign cmp[g] = (cnt < duty_act[g]) ^ pol_act[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= cmp;
    end
  end

endmodule
